// File: rtl/peripheral_uart_pkg.sv
// Shared definitions for the UART peripheral: parameter defaults and the transmitter state type.
package peripheral_uart_pkg;

   localparam int unsigned DIV_W_DEFAULT  = 16;
   localparam int unsigned DATA_W_DEFAULT = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_tx_state_e;

endpackage

// File: rtl/peripheral_uart_baud_gen.sv
// Bit-period divider: loads a reload value, counts down to zero, ticks and reloads at zero.
module peripheral_uart_baud_gen
   import peripheral_uart_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = div;
      end else if (en) begin
         if (cnt_q == '0) begin
            cnt_d = div;
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
      end
   end

   assign tick = en && !load && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/peripheral_uart_tx.sv
// UART transmitter: start bit, DATA_W bits LSB first, optional parity, one stop bit.
// Parity is built in only when PERIPHERAL_UART_TX_PARITY_EN is defined.
module peripheral_uart_tx
   import peripheral_uart_pkg::*;
#(
   parameter int unsigned DIV_W  = DIV_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  baud_div,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              cfg_parity_odd,
   output logic              tx_busy,
   output logic              uart_txd
);

   localparam int unsigned CntW = $clog2(DATA_W + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

   uart_tx_state_e    state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              txd_q, txd_d;
   logic              transfer;
   logic              tick;

   assign tx_ready = (state_q == StIdle);
   assign tx_busy  = (state_q != StIdle);
   assign transfer = tx_valid && tx_ready;
   assign uart_txd = txd_q;

`ifdef PERIPHERAL_UART_TX_PARITY_EN
   // Parity is folded at capture time so the shifting data register can be consumed freely.
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (transfer) begin
         par_d = (^tx_data) ^ cfg_parity_odd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`else
   logic unused_parity_odd;
   assign unused_parity_odd = cfg_parity_odd;
`endif

   peripheral_uart_baud_gen #(
      .DIV_W (DIV_W)
   ) u_baud_gen (
      .clk  (clk),
      .rst  (rst),
      .load (transfer),
      .en   (tx_busy),
      .div  (transfer ? baud_div : div_q),
      .tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      div_d     = div_q;
      case (state_q)
         StIdle: begin
            if (tx_valid) begin
               state_d   = StStart;
               shreg_d   = tx_data;
               div_d     = baud_div;
               bit_cnt_d = '0;
            end
         end
         StStart: begin
            if (tick) state_d = StData;
         end
         StData: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == LastBit) begin
                  bit_cnt_d = '0;
`ifdef PERIPHERAL_UART_TX_PARITY_EN
                  state_d   = StParity;
`else
                  state_d   = StStop;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end
`ifdef PERIPHERAL_UART_TX_PARITY_EN
         StParity: begin
            if (tick) state_d = StStop;
         end
`endif
         StStop: begin
            if (tick) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Line value is decoded from the next state so uart_txd comes straight from a flop.
   always_comb begin
      txd_d = 1'b1;
      case (state_d)
         StStart:  txd_d = 1'b0;
         StData:   txd_d = shreg_d[0];
`ifdef PERIPHERAL_UART_TX_PARITY_EN
         StParity: txd_d = par_q;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         div_q     <= '0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         div_q     <= div_d;
         txd_q     <= txd_d;
      end
   end

endmodule
